// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied in a final FIX cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  // Handshake: start is accepted only in IDLE (and only without flush); stall tells
  // the pipeline to hold while a request is being accepted or is in flight; done is
  // a one-cycle pulse and result is valid while it is high, then holds until the next done.

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  logic [2:0]       op_q;
  logic [XLEN-1:0]  m_reg;   // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [XLEN-1:0]  acc;     // product high word (mul) or partial remainder (div)
  logic [XLEN-1:0]  lo;      // multiplier / product low word (mul) or dividend / quotient (div)
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;

  // Request decode, only meaningful in IDLE.
  logic            in_is_div;
  logic            in_signed_a;
  logic            in_signed_b;
  logic            in_sgn_a;
  logic            in_sgn_b;
  logic [XLEN-1:0] in_abs_a;
  logic [XLEN-1:0] in_abs_b;
  logic            in_div_zero;
  logic            in_div_ovf;
  logic            in_special;

  always_comb begin
    in_is_div   = funct3[2];
    in_signed_a = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                  (funct3 == F_DIV) || (funct3 == F_REM);
    in_signed_b = (funct3 == F_MUL) || (funct3 == F_MULH) ||
                  (funct3 == F_DIV) || (funct3 == F_REM);
    in_sgn_a    = in_signed_a & op_a[XLEN-1];
    in_sgn_b    = in_signed_b & op_b[XLEN-1];
    in_abs_a    = in_sgn_a ? (~op_a + 1'b1) : op_a;
    in_abs_b    = in_sgn_b ? (~op_b + 1'b1) : op_b;
    in_div_zero = in_is_div && (op_b == '0);
    in_div_ovf  = in_is_div && !funct3[0] && (op_a == INT_MIN) && (op_b == ALL_ONE);
    in_special  = in_div_zero || in_div_ovf;
  end

  // One radix-2 step of either algorithm.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] step_acc;
  logic [XLEN-1:0] step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, m_reg} : {(XLEN+1){1'b0}});
    rem_sh   = {acc, lo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, m_reg};
    step_acc = acc;
    step_lo  = lo;
    if (op_q[2]) begin
      if (!rem_diff[XLEN]) begin
        step_acc = rem_diff[XLEN-1:0];
        step_lo  = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_acc = rem_sh[XLEN-1:0];
        step_lo  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign correction and result word selection.
  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_raw = {acc, lo};
    prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = neg_q ? (~lo + 1'b1) : lo;
    rem_fix  = neg_r ? (~acc + 1'b1) : acc;
    fix_res  = '0;
    case (op_q)
      F_MUL:                      fix_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              fix_res = quo_fix;
      F_REM, F_REMU:              fix_res = rem_fix;
      default:                    fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      m_reg  <= '0;
      acc    <= '0;
      lo     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= funct3;
            if (in_div_zero) begin
              m_reg <= '0;
              acc   <= op_a;
              lo    <= ALL_ONE;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (in_div_ovf) begin
              m_reg <= '0;
              acc   <= '0;
              lo    <= INT_MIN;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (in_is_div) begin
              m_reg <= in_abs_b;
              acc   <= '0;
              lo    <= in_abs_a;
              neg_q <= in_sgn_a ^ in_sgn_b;
              neg_r <= in_sgn_a;
            end else begin
              m_reg <= in_abs_a;
              acc   <= '0;
              lo    <= in_abs_b;
              neg_q <= in_sgn_a ^ in_sgn_b;
              neg_r <= 1'b0;
            end
            if (in_special) begin
              state <= FIX;
              cnt   <= '0;
            end else begin
              state <= CALC;
              cnt   <= CNT_W'(XLEN-1);
            end
          end
        end
        CALC: begin
          acc <= step_acc;
          lo  <= step_lo;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          result <= fix_res;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == CALC) || (state == FIX);
  assign done      = (state == DONE);
  assign stall     = (start & ~flush & (state == IDLE)) | busy;
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, hand-written flush/reset/hold
// sequences, and randomized ops scored against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int n_pass    = 0;
  int n_total   = 0;
  int done_seen = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'd0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock and pulse counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic from the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ub;
    longint unsigned uu;
    logic [63:0]     p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin uu = longint'({32'd0, a}) * longint'({32'd0, b}); p = uu; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Driver tasks. Cycle 1 is the cycle right after the start-sampling edge.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 1;
    busy_n = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen_in_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int busy_n);
    @(negedge clk);
    while (busy === 1'b1 || done === 1'b1) @(negedge clk);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    wait_done(cyc, busy_n);
  endtask

  initial begin
    int          cyc;
    int          busy_n;
    int          seen0;
    logic [31:0] e;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
    vecs[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 2};
    vecs[13] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[14] = '{3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         34};
    vecs[15] = '{3'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 34};
    vecs[16] = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[17] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};
    vecs[18] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[19] = '{3'd7, 32'd9,          32'd0,         32'd9,         2};
    vecs[20] = '{3'd1, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[21] = '{3'd4, 32'd0,          32'd5,         32'd0,         34};

    // Reset
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_state_idle", {30'd0, state_dbg}, 32'd0);
    start = 1'b1;
    #1;
    check("rst_stall_with_start", {31'd0, stall}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, cyc, busy_n);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].lat - 1));
      last_exp = vecs[i].exp;
    end

    // flush wins over start in IDLE
    @(negedge clk);
    while (busy === 1'b1 || done === 1'b1) @(negedge clk);
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    check("idle_flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_no_start", {31'd0, busy}, 32'd0);

    // Flush mid-MUL together with start, then a fresh start at cycle 12
    @(negedge clk);
    seen0 = done_seen;
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b1; op_a = 32'd11; op_b = 32'd13;
    check("flush_stall_busy", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    check("flush_no_done", {31'd0, done}, 32'd0);
    check("flush_result_kept", result, last_exp);
    @(posedge clk); #1;
    check("flush_still_idle", {31'd0, busy}, 32'd0);
    start = 1'b1;
    #1;
    check("restart_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, busy_n);
    check("restart_result", result, 32'd143);
    check("restart_latency", 32'(cyc), 32'd34);
    last_exp = 32'd143;
    @(posedge clk); #1;
    check("flush_done_pulses", 32'(done_seen - seen0), 32'd1);

    // Reset in the middle of a DIV
    @(negedge clk);
    seen0 = done_seen;
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_seen - seen0), 32'd0);
    last_exp = 32'd0;

    // start held high and operands churning while busy
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'd12345;
    e = ref_model(3'd4, a, b);
    funct3 = 3'd4; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("hold_start_done", {31'd0, done}, 32'd1);
    check("hold_start_result", result, e);
    check("hold_start_latency", 32'(cyc), 32'd34);
    last_exp = e;

    // flush in the DONE cycle
    e = ref_model(3'd7, 32'd1001, 32'd10);
    run_op(3'd7, 32'd1001, 32'd10, cyc, busy_n);
    flush = 1'b1;
    #1;
    check("done_flush_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_idle", {31'd0, done | busy}, 32'd0);
    check("done_flush_result", result, e);
    last_exp = e;

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      exp_q.push_back(ref_model(f3, a, b));
      run_op(f3, a, b, cyc, busy_n);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_f%0d_%h_%h", i, f3, a, b), result, e);
      check($sformatf("rand%0d_latency", i), 32'(cyc), 32'(ref_lat(f3, a, b)));
      last_exp = e;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
